// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer: gathers RATIO beats (or fewer, closed by wlast)
// into one wide word with per-lane keep bits, behind a single output register.
module stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        wvalid,
    input  logic                        wlast,
    output logic                        wready,
    output logic [DATA_WIDTH*RATIO-1:0] rdata,
    output logic [RATIO-1:0]            rkeep,
    output logic                        rlast,
    output logic                        rvalid,
    input  logic                        rready
);

    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    logic [DATA_WIDTH*RATIO-1:0] asm_data;
    logic [DATA_WIDTH*RATIO-1:0] merged_data;
    logic [RATIO-1:0]            asm_keep;
    logic [RATIO-1:0]            merged_keep;
    logic [CNT_W-1:0]            cnt;
    logic                        w_fire;
    logic                        r_fire;
    logic                        complete;

    // The output slot frees up whenever it is empty or being drained this cycle.
    assign wready   = ~rvalid | rready;
    assign w_fire   = wvalid & wready;
    assign r_fire   = rvalid & rready;
    assign complete = w_fire & ((cnt == CNT_MAX) | wlast);

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        merged_data = asm_data;
        merged_keep = asm_keep;
        merged_data[cnt*DATA_WIDTH +: DATA_WIDTH] = wdata;
        merged_keep[cnt] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_data <= '0;
            asm_keep <= '0;
            cnt      <= '0;
            rdata    <= '0;
            rkeep    <= '0;
            rlast    <= 1'b0;
            rvalid   <= 1'b0;
        end else begin
            if (r_fire) begin
                rvalid <= 1'b0;
            end
            // A completing beat overrides the drain, giving back-to-back words with no bubble.
            if (complete) begin
                rdata    <= merged_data;
                rkeep    <= merged_keep;
                rlast    <= wlast;
                rvalid   <= 1'b1;
                asm_data <= '0;
                asm_keep <= '0;
                cnt      <= '0;
            end else if (w_fire) begin
                asm_data <= merged_data;
                asm_keep <= merged_keep;
                cnt      <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer (DATA_WIDTH=8, RATIO=4): a table of
// per-cycle vectors plus hand-written reset sequences.
module tb_stream_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  wdata = '0;
    logic        wvalid = 1'b0;
    logic        wlast = 1'b0;
    logic        wready;
    logic [31:0] rdata;
    logic [3:0]  rkeep;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int tests  = 0;
    int failed = 0;

    stream_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wlast  (wlast),
        .wready (wready),
        .rdata  (rdata),
        .rkeep  (rkeep),
        .rlast  (rlast),
        .rvalid (rvalid),
        .rready (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [7:0]  wd;
        logic        wl;
        logic        rr;
        logic        e_wready;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic [3:0]  e_rkeep;
        logic        e_rlast;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wv, logic [7:0] wd, logic wl, logic rr,
                                logic ewr, logic erv, logic [31:0] erd,
                                logic [3:0] erk, logic erl);
        vec_t v;
        v.wv = wv; v.wd = wd; v.wl = wl; v.rr = rr;
        v.e_wready = ewr; v.e_rvalid = erv; v.e_rdata = erd;
        v.e_rkeep = erk; v.e_rlast = erl;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, check wready before the rising edge and the
    // registered outputs just after it. Output payload is checked only when valid.
    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        wvalid = v.wv;
        wdata  = v.wd;
        wlast  = v.wl;
        rready = v.rr;
        #1;
        check({tag, ".wready"}, 32'(wready), 32'(v.e_wready));
        @(posedge clk);
        #1;
        check({tag, ".rvalid"}, 32'(rvalid), 32'(v.e_rvalid));
        if (v.e_rvalid) begin
            check({tag, ".rdata"}, rdata, v.e_rdata);
            check({tag, ".rkeep"}, 32'(rkeep), 32'(v.e_rkeep));
            check({tag, ".rlast"}, 32'(rlast), 32'(v.e_rlast));
        end
    endtask

    task automatic check_reset_state(string tag);
        check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
        check({tag, ".rdata"},  rdata, 32'd0);
        check({tag, ".rkeep"},  32'(rkeep), 32'd0);
        check({tag, ".rlast"},  32'(rlast), 32'd0);
        check({tag, ".wready"}, 32'(wready), 32'd1);
    endtask

    initial begin
        // Full words with rready held high: wready must never drop.
        vecs.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0));
        vecs.push_back(mk(1, 8'h55, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h66, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h77, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h88, 0, 1, 1, 1, 32'h88776655, 4'hF, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        // Early flush, then the next beat must restart at lane 0.
        vecs.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1));
        vecs.push_back(mk(1, 8'hCC, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hDD, 1, 1, 1, 1, 32'h0000DDCC, 4'h3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        // Single-beat flush.
        vecs.push_back(mk(1, 8'h5A, 1, 1, 1, 1, 32'h0000005A, 4'h1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        // Backpressure: 0x99 is refused while stalled, then lands in lane 0.
        vecs.push_back(mk(1, 8'hE1, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hE2, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hE3, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hE4, 0, 0, 1, 1, 32'hE4E3E2E1, 4'hF, 0));
        vecs.push_back(mk(1, 8'h99, 0, 0, 0, 1, 32'hE4E3E2E1, 4'hF, 0));
        vecs.push_back(mk(1, 8'h99, 0, 0, 0, 1, 32'hE4E3E2E1, 4'hF, 0));
        vecs.push_back(mk(1, 8'h99, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h98, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h97, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h96, 0, 0, 1, 1, 32'h96979899, 4'hF, 0));
        // Drain and complete in the same cycle: no bubble between words.
        vecs.push_back(mk(1, 8'hB1, 1, 1, 1, 1, 32'h000000B1, 4'h1, 1));
        vecs.push_back(mk(1, 8'hB2, 1, 1, 1, 1, 32'h000000B2, 4'h1, 1));
        vecs.push_back(mk(1, 8'hC1, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC2, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC3, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC4, 1, 1, 1, 1, 32'hC4C3C2C1, 4'hF, 1));
        vecs.push_back(mk(1, 8'hD1, 1, 1, 1, 1, 32'h000000D1, 4'h1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));

        #1;
        check_reset_state("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset with a full word pending and the consumer stalled.
        apply(mk(1, 8'hF1, 0, 0, 1, 0, 32'h0, 4'h0, 0), "rsta0");
        apply(mk(1, 8'hF2, 0, 0, 1, 0, 32'h0, 4'h0, 0), "rsta1");
        apply(mk(1, 8'hF3, 0, 0, 1, 0, 32'h0, 4'h0, 0), "rsta2");
        apply(mk(1, 8'hF4, 0, 0, 1, 1, 32'hF4F3F2F1, 4'hF, 0), "rsta3");
        @(negedge clk);
        wvalid = 1'b0;
        rready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_state("rst_pending");
        @(negedge clk);
        rst = 1'b1;

        // Reset with two beats partially assembled; the partial word is dropped.
        apply(mk(1, 8'h71, 0, 1, 1, 0, 32'h0, 4'h0, 0), "rstb0");
        apply(mk(1, 8'h72, 0, 1, 1, 0, 32'h0, 4'h0, 0), "rstb1");
        @(negedge clk);
        wvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_state("rst_partial");
        @(negedge clk);
        rst = 1'b1;

        apply(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post0");
        apply(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post1");
        apply(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post2");
        apply(mk(1, 8'h04, 0, 1, 1, 1, 32'h04030201, 4'hF, 0), "post3");
        apply(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post4");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
